updown_counter_mod: RTL and testbench

Parametrised up/down counter with these features:
- configurable width and modulus
- synchronous clear and parallel load
- count enable
- wrap or saturate behaviour at the count limits
- boundary status flags
This is the general-purpose counter for switch/LED demo tops and for the timer/index logic in larger datapaths.

---
 rtl/updown_counter_mod.sv | 95 +++++++++
 tb/tb_updown_counter_mod.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter, modulo MAX_VAL+1, with clear/load/enable, wrap or saturate, and boundary flags.
// Define UDC_EN_EDGE_EN to treat en as a synchronised rising-edge step request.
module updown_counter_mod #(
  parameter int unsigned      WIDTH    = 4,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             up,
  output logic [WIDTH-1:0] q,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap,
  output logic             ovf
);

  logic             step;
  logic [WIDTH-1:0] q_next;
  logic             hit;

`ifdef UDC_EN_EDGE_EN
  logic en_s1, en_s2, en_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_s1   <= 1'b0;
      en_s2   <= 1'b0;
      en_prev <= 1'b0;
    end else begin
      en_s1   <= en;
      en_s2   <= en_s1;
      en_prev <= en_s2;
    end
  end

  // An edge seen while clr/load wins is simply dropped; en_prev still advances.
  assign step = en_s2 & ~en_prev;
`else
  assign step = en;
`endif

  // Out-of-range q (only reachable by corruption) is forced back into range as a boundary hit.
  always_comb begin
    q_next = q;
    hit    = 1'b0;
    if (up) begin
      if (q < MAX_VAL) begin
        q_next = q + 1'b1;
      end else begin
        hit    = 1'b1;
        q_next = (SATURATE && q == MAX_VAL) ? q : '0;
      end
    end else begin
      if (q > MAX_VAL) begin
        hit    = 1'b1;
        q_next = MAX_VAL;
      end else if (q != '0) begin
        q_next = q - 1'b1;
      end else begin
        hit    = 1'b1;
        q_next = SATURATE ? q : MAX_VAL;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      q    <= (load_val > MAX_VAL) ? MAX_VAL : load_val;
      wrap <= 1'b0;
    end else if (step) begin
      q    <= q_next;
      wrap <= hit;
      if (hit) ovf <= 1'b1;
    end else begin
      wrap <= 1'b0;
    end
  end

  assign at_max = (q == MAX_VAL);
  assign at_min = (q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed self-checking bench: a mod-10 wrapping counter and a 4-bit saturating counter.
module tb_updown_counter_mod;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_clr, a_load, a_en, a_up;
  logic [3:0] a_load_val;
  logic [3:0] a_q;
  logic       a_at_max, a_at_min, a_wrap, a_ovf;
  logic       b_clr, b_load, b_en, b_up;
  logic [3:0] b_load_val;
  logic [3:0] b_q;
  logic       b_at_max, b_at_min, b_wrap, b_ovf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .clr(a_clr), .load(a_load), .load_val(a_load_val),
    .en(a_en), .up(a_up), .q(a_q), .at_max(a_at_max), .at_min(a_at_min),
    .wrap(a_wrap), .ovf(a_ovf)
  );

  updown_counter_mod #(.WIDTH(4), .SATURATE(1'b1)) dut_b (
    .clk(clk), .rst(rst), .clr(b_clr), .load(b_load), .load_val(b_load_val),
    .en(b_en), .up(b_up), .q(b_q), .at_max(b_at_max), .at_min(b_at_min),
    .wrap(b_wrap), .ovf(b_ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_load_value(input logic [3:0] v);
    a_load = 1'b1; a_load_val = v;
    tick();
    a_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    a_clr = 0; a_load = 0; a_en = 0; a_up = 1; a_load_val = '0;
    b_clr = 0; b_load = 0; b_en = 0; b_up = 1; b_load_val = '0;
    #12;
    check("rst_q",      a_q, 0);
    check("rst_at_min", a_at_min, 1);
    check("rst_at_max", a_at_max, 0);
    check("rst_wrap",   a_wrap, 0);
    check("rst_ovf",    a_ovf, 0);
    check("rst_b_q",    b_q, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();

`ifdef UDC_EN_EDGE_EN
    a_up = 1'b1; a_en = 1'b1;
    tick(); check("edge_e1", a_q, 0);
    tick(); check("edge_e2", a_q, 0);
    tick(); check("edge_e3", a_q, 1);
    for (int i = 0; i < 7; i++) tick();
    check("edge_hold", a_q, 1);
    a_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("edge_low", a_q, 1);
    a_en = 1'b1;
    tick(); tick();
    check("edge2_e2", a_q, 1);
    tick();
    check("edge2_e3", a_q, 2);
    a_en = 1'b0;
    for (int i = 0; i < 4; i++) tick();
`else
    // Wrap up from 8 with MAX_VAL=9
    a_load_value(4'd8);
    check("load8", a_q, 8);
    a_en = 1'b1; a_up = 1'b1;
    tick(); check("up_q9", a_q, 9); check("up_wrap9", a_wrap, 0); check("up_atmax", a_at_max, 1);
    tick(); check("up_q0", a_q, 0); check("up_wrap0", a_wrap, 1); check("up_ovf0", a_ovf, 1);
    tick(); check("up_q1", a_q, 1); check("up_wrap1", a_wrap, 0); check("up_ovf1", a_ovf, 1);

    // Wrap down from 1
    a_up = 1'b0;
    tick(); check("dn_q0", a_q, 0); check("dn_wrap0", a_wrap, 0); check("dn_atmin", a_at_min, 1);
    tick(); check("dn_q9", a_q, 9); check("dn_wrap9", a_wrap, 1);
    tick(); check("dn_q8", a_q, 8); check("dn_wrap8", a_wrap, 0);
    a_en = 1'b0;
    tick(); check("hold_q8", a_q, 8);

    // Load keeps the sticky flag
    a_load_value(4'd3);
    check("load_q3", a_q, 3); check("load_ovf", a_ovf, 1);

    // Asynchronous reset mid-count
    a_load_value(4'd9);
    check("pre_rst_q", a_q, 9);
    #2 rst = 1'b1;
    #1;
    check("arst_q", a_q, 0); check("arst_ovf", a_ovf, 0); check("arst_atmin", a_at_min, 1);
    #2 rst = 1'b0;
    tick();

    // clr beats load, then load clamps
    a_load_value(4'd9);
    a_en = 1'b1; a_up = 1'b1;
    tick(); check("pre_clr_ovf", a_ovf, 1);
    a_en = 1'b0;
    a_clr = 1'b1; a_load = 1'b1; a_load_val = 4'd5;
    tick();
    a_clr = 1'b0; a_load = 1'b0;
    check("clr_q", a_q, 0); check("clr_ovf", a_ovf, 0);
    a_load_value(4'd12);
    check("clamp_q", a_q, 9);

    // Saturating counter at both ends
    b_load = 1'b1; b_load_val = 4'd14;
    tick();
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b1;
    tick(); check("sat_q1", b_q, 15); check("sat_w1", b_wrap, 0); check("sat_atmax", b_at_max, 1);
    tick(); check("sat_q2", b_q, 15); check("sat_w2", b_wrap, 1); check("sat_ovf", b_ovf, 1);
    tick(); check("sat_q3", b_q, 15); check("sat_w3", b_wrap, 1);
    b_en = 1'b0; b_load = 1'b1; b_load_val = 4'd1;
    tick();
    b_load = 1'b0; b_en = 1'b1; b_up = 1'b0;
    tick(); check("satd_q0", b_q, 0); check("satd_w0", b_wrap, 0);
    tick(); check("satd_q1", b_q, 0); check("satd_w1", b_wrap, 1);
    b_en = 1'b0;
    tick(); check("satd_wclr", b_wrap, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
